rpsc_interlock_card: RTL and testbench
======================================

# rpsc_interlock_card

Parametrised successor to the RPSC card-6 alarm logic: aggregates N_CH power-supply and RF control fault requests into a debounced, latched interlock. Adds external emergency handling, tune-ok qualification for anode over-current threshold selection, and first-fault capture. Sits between the per-supply control cards and the RPSC permit chain; `o_not_alarm` and `o_emergency` feed the permit/crowbar logic directly.

## Interface
- `N_CH`, default 6: number of fault request channels (1..32).
- `DEB_CYCLES`, default 4: consecutive high samples before a channel fault qualifies (>=1).
- `TUNE_DLY`, default 8: consecutive cycles `i_not_tune_ok` must be low before tune-ok is considered established (>=1).

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_control`  in  N_CH  per-channel fault request, active high.
- `i_external`  in  1  external emergency request, active high.
- `i_not_tune_ok`  in  1  tune not OK, active high, raw.
- `i_i_an_5a`  in  1  anode current above 5 A comparator.
- `i_i_an_6a`  in  1  anode current above 6 A comparator.
- `i_ack`  in  1  operator acknowledge, single-cycle pulse.
- `o_not_alarm`  out  1  high only in RUN.
- `o_emergency`  out  1  high only in EMERG.
- `o_i_an_high`  out  1  active-low anode over-current indication.
- `o_alarm_latched`  out  N_CH  latched fault per channel.
- `o_first_fault`  out  CW = max(1, $clog2(N_CH))  index of the first qualified fault.
- `o_first_valid`  out  1  `o_first_fault` holds a capture.

## Operation
- Reset values: state RUN; `o_not_alarm`=1; `o_emergency`=0; `o_i_an_high`=1; `o_alarm_latched`=0; `o_first_fault`=0; `o_first_valid`=0. All debounce and tune counters are 0; tune-ok is not established.
- Debounce, per channel: a saturating counter increments while the input is high and clears on any low sample. The channel qualifies on the edge where the counter reaches DEB_CYCLES and stays qualified while the input remains high.
- Latch: on qualification, the channel's `o_alarm_latched` bit sets on the same edge. The bit holds until acknowledged.
- Tune qualification: a counter tracks consecutive low samples of `i_not_tune_ok`. `tune_ok` asserts when the count reaches TUNE_DLY and drops on the first high sample.
- Anode threshold: `o_i_an_high` is registered as ~((~tune_ok & i_i_an_5a) | (tune_ok & i_i_an_6a)). While not tuned, the 5 A limit applies; once tuned, the 6 A limit applies.
- FSM states RUN, ALARM, EMERG:
  - RUN -> ALARM: any bit of `o_alarm_latched` is set.
  - Any state -> EMERG: `i_external` is sampled high. This has priority over everything else.
  - EMERG exit requires `i_ack` while `i_external` is low. The FSM goes to ALARM if any latched bit remains after the ack, otherwise to RUN.
  - ALARM -> RUN: `i_ack` clears every latched bit.
- Acknowledge: `i_ack` clears each latched bit whose channel is not currently qualified. A still-qualified channel stays latched. If a new qualification and an ack land on the same edge, the bit stays set.
- `i_ack` while `i_external` is high has no effect on state; latched bits are still cleared per the rule above.
- First fault: captured only while `o_first_valid`=0, on the edge that first sets any latched bit. If several channels qualify on that edge, the lowest index wins. Capture clears when the FSM enters RUN.
- Reset asserted mid-operation returns every register to its reset value on the next edge, whatever state the FSM is in.

## Timing
- Channel fault: `i_control[k]` high from cycle 0 gives `o_alarm_latched[k]`=1 and `o_not_alarm`=0 after edge DEB_CYCLES. A pulse shorter than DEB_CYCLES leaves no trace.
- External: `i_external` sampled high at edge n gives `o_emergency`=1 and `o_not_alarm`=0 after edge n. The input is not debounced.
- Ack: takes effect on the edge that samples it, so outputs update one cycle later.
- Tune: `i_not_tune_ok` falling at cycle 0 makes the 6 A selection visible at `o_i_an_high` after edge TUNE_DLY+1. A rise returns the 5 A selection after one edge.
- `o_i_an_high`: one-cycle registered latency from the comparator inputs.

## Configuration
- `RPSC_FIRST_FAULT_EN` defined: first-fault capture is built as described above.
- `RPSC_FIRST_FAULT_EN` undefined: the capture logic is omitted, and `o_first_fault`=0 and `o_first_valid`=0 permanently. Ports remain, and all other behaviour is identical.

## Test plan
- Debounce (N_CH=6, DEB_CYCLES=4): `i_control[2]` high 3 cycles then low -> `o_alarm_latched`=0, `o_not_alarm` stays 1. Held 4 cycles -> `o_alarm_latched`=6'b000100, `o_not_alarm`=0, `o_first_fault`=2.
- Simultaneous faults: `i_control[5]` and `i_control[1]` rise on the same cycle -> `o_first_fault`=1. A later `i_control[0]` fault does not change `o_first_fault`.
- Ack with a fault still active: `i_control[3]` stays high and `i_ack` is pulsed -> bit 3 stays latched, state ALARM. Drop the input, pulse ack -> latched=0, `o_not_alarm`=1, `o_first_valid`=0.
- Emergency: `i_external` high during ALARM -> `o_emergency`=1 next cycle. Ack while still high -> no change. Release, then ack with bit 1 latched and channel 1 still qualified -> ALARM, `o_emergency`=0.
- Tune (TUNE_DLY=8): `i_i_an_5a`=1, `i_i_an_6a`=0, `i_not_tune_ok` falls -> `o_i_an_high`=0 until after edge 9, then 1. Raise `i_not_tune_ok` -> 0 again after one edge.
- Reset during EMERG with latched bits -> next cycle all outputs at their reset values.

Source files
------------

// File: rtl/rpsc_interlock_card.sv
// rpsc_interlock_card
//
// Parametrised RPSC interlock card. Collects N_CH fault requests coming from
// the power-supply and RF control cards. Each request is debounced and then
// latched. The latched faults, together with the external emergency input,
// drive a RUN / ALARM / EMERG state machine. The card also selects the anode
// over-current threshold: 5 A until tune-ok is established, 6 A after that.
//
// Optional feature: define RPSC_FIRST_FAULT_EN to build first-fault capture.
// Without it, o_first_fault and o_first_valid are tied to 0.
//
// Ports:
//   clk              rising-edge clock for every register
//   reset            synchronous, active-high reset
//   i_control        [N_CH] per-channel fault request, active high
//   i_external       external emergency request, active high, not debounced
//   i_not_tune_ok    raw "tune not OK", active high
//   i_i_an_5a        anode current > 5 A comparator
//   i_i_an_6a        anode current > 6 A comparator
//   i_ack            operator acknowledge, single-cycle pulse
//   o_not_alarm      high only in RUN
//   o_emergency      high only in EMERG
//   o_i_an_high      active-low anode over-current indication (registered)
//   o_alarm_latched  [N_CH] latched fault per channel
//   o_first_fault    [CW] index of the first qualified fault
//   o_first_valid    o_first_fault holds a capture
module rpsc_interlock_card #(
    parameter int N_CH       = 6,
    parameter int DEB_CYCLES = 4,
    parameter int TUNE_DLY   = 8,
    localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] i_control,
    input  logic            i_external,
    input  logic            i_not_tune_ok,
    input  logic            i_i_an_5a,
    input  logic            i_i_an_6a,
    input  logic            i_ack,
    output logic            o_not_alarm,
    output logic            o_emergency,
    output logic            o_i_an_high,
    output logic [N_CH-1:0] o_alarm_latched,
    output logic [CW-1:0]   o_first_fault,
    output logic            o_first_valid
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TUNE_DLY + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_QUAL = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TUNE_MAX = TW'(TUNE_DLY);

    typedef enum logic [1:0] {ST_RUN, ST_ALARM, ST_EMERG} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   deb_cnt_q [N_CH];
    logic [DW-1:0]   deb_cnt_d [N_CH];
    logic [N_CH-1:0] qual;
    logic [N_CH-1:0] latched_q, latched_d;
    logic [TW-1:0]   tune_cnt_q, tune_cnt_d;
    logic            tune_ok;
    logic            an_high_q, an_high_d;

    // A channel is qualified on the edge where its counter reaches
    // DEB_CYCLES, and it stays qualified while the input remains high.
    // The counter saturates, so the >= test also covers the held case.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            qual[k] = i_control[k] && (deb_cnt_q[k] >= DEB_QUAL);
            if (!i_control[k]) begin
                deb_cnt_d[k] = '0;
            end else if (deb_cnt_q[k] != DEB_MAX) begin
                deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
            end else begin
                deb_cnt_d[k] = deb_cnt_q[k];
            end
        end
    end

    // An ack clears only the channels that are not qualified. A
    // qualification on the same edge as an ack always wins.
    always_comb begin
        latched_d = (i_ack ? (latched_q & qual) : latched_q) | qual;
    end

    // tune_ok drops combinationally on the first high sample. A rise of
    // i_not_tune_ok therefore restores the 5 A limit after a single edge.
    always_comb begin
        if (i_not_tune_ok) begin
            tune_cnt_d = '0;
        end else if (tune_cnt_q != TUNE_MAX) begin
            tune_cnt_d = tune_cnt_q + 1'b1;
        end else begin
            tune_cnt_d = tune_cnt_q;
        end
        tune_ok   = !i_not_tune_ok && (tune_cnt_q == TUNE_MAX);
        an_high_d = ~((~tune_ok & i_i_an_5a) | (tune_ok & i_i_an_6a));
    end

    // Next-state logic and state-decoded outputs. Transitions look at
    // latched_d, so an alarm becomes visible on the same edge it latches.
    always_comb begin
        state_d     = state_q;
        o_not_alarm = 1'b0;
        o_emergency = 1'b0;
        if (i_external) begin
            state_d = ST_EMERG;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (|latched_d) state_d = ST_ALARM;
                end
                ST_ALARM: begin
                    if (i_ack && (latched_d == '0)) state_d = ST_RUN;
                end
                ST_EMERG: begin
                    if (i_ack) state_d = (|latched_d) ? ST_ALARM : ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
        case (state_q)
            ST_RUN:   o_not_alarm = 1'b1;
            ST_EMERG: o_emergency = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            latched_q  <= '0;
            tune_cnt_q <= '0;
            an_high_q  <= 1'b1;
            for (int k = 0; k < N_CH; k++) deb_cnt_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            latched_q  <= latched_d;
            tune_cnt_q <= tune_cnt_d;
            an_high_q  <= an_high_d;
            for (int k = 0; k < N_CH; k++) deb_cnt_q[k] <= deb_cnt_d[k];
        end
    end

    assign o_alarm_latched = latched_q;
    assign o_i_an_high     = an_high_q;

`ifdef RPSC_FIRST_FAULT_EN
    logic [CW-1:0]   ff_q, ff_d;
    logic            ffv_q, ffv_d;
    logic [N_CH-1:0] new_set;

    function automatic logic [CW-1:0] lowest_idx(input logic [N_CH-1:0] v);
        logic [CW-1:0] res;
        res = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (v[k]) res = CW'(k);
        end
        return res;
    endfunction

    // The capture is taken only from bits that set on this edge, so that
    // faults already latched can never overwrite it.
    always_comb begin
        new_set = qual & ~latched_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
            ff_d  = '0;
            ffv_d = 1'b0;
        end else if (!ffv_q && (|new_set)) begin
            ff_d  = lowest_idx(new_set);
            ffv_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ff_q  <= '0;
            ffv_q <= 1'b0;
        end else begin
            ff_q  <= ff_d;
            ffv_q <= ffv_d;
        end
    end

    assign o_first_fault = ff_q;
    assign o_first_valid = ffv_q;
`else
    assign o_first_fault = '0;
    assign o_first_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rpsc_interlock_card.sv
// Directed testbench for rpsc_interlock_card (N_CH=6, DEB_CYCLES=4, TUNE_DLY=8).
// Inputs are driven 1 ns after the rising edge. Outputs are sampled at the
// same point, so they show the result of the edge that just occurred.
module tb_rpsc_interlock_card;

    localparam int N_CH = 6;
    localparam int CW   = 3;
`ifdef RPSC_FIRST_FAULT_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] i_control;
    logic            i_external, i_not_tune_ok, i_i_an_5a, i_i_an_6a, i_ack;
    logic            o_not_alarm, o_emergency, o_i_an_high, o_first_valid;
    logic [N_CH-1:0] o_alarm_latched;
    logic [CW-1:0]   o_first_fault;

    int checks = 0;
    int errors = 0;

    rpsc_interlock_card #(.N_CH(6), .DEB_CYCLES(4), .TUNE_DLY(8)) dut (
        .clk(clk), .reset(reset), .i_control(i_control), .i_external(i_external),
        .i_not_tune_ok(i_not_tune_ok), .i_i_an_5a(i_i_an_5a), .i_i_an_6a(i_i_an_6a),
        .i_ack(i_ack), .o_not_alarm(o_not_alarm), .o_emergency(o_emergency),
        .o_i_an_high(o_i_an_high), .o_alarm_latched(o_alarm_latched),
        .o_first_fault(o_first_fault), .o_first_valid(o_first_valid)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        checks++; if (o_not_alarm !== 1'b1) begin errors++; $display("FAIL reset_not_alarm: got %b exp 1", o_not_alarm); end
        checks++; if (o_emergency !== 1'b0) begin errors++; $display("FAIL reset_emergency: got %b exp 0", o_emergency); end
        checks++; if (o_i_an_high !== 1'b1) begin errors++; $display("FAIL reset_an_high: got %b exp 1", o_i_an_high); end
        checks++; if (o_alarm_latched !== 6'b0) begin errors++; $display("FAIL reset_latched: got %b exp 000000", o_alarm_latched); end
        checks++; if (o_first_fault !== 3'd0) begin errors++; $display("FAIL reset_first_fault: got %0d exp 0", o_first_fault); end
        checks++; if (o_first_valid !== 1'b0) begin errors++; $display("FAIL reset_first_valid: got %b exp 0", o_first_valid); end
    endtask

    task automatic test_debounce();
        i_control = 6'b000100;
        tick(3);
        i_control = 6'b0;
        tick(2);
        checks++; if (o_alarm_latched !== 6'b0) begin errors++; $display("FAIL deb_short_latched: got %b exp 000000", o_alarm_latched); end
        checks++; if (o_not_alarm !== 1'b1) begin errors++; $display("FAIL deb_short_not_alarm: got %b exp 1", o_not_alarm); end
        i_control = 6'b000100;
        tick(3);
        checks++; if (o_alarm_latched !== 6'b0) begin errors++; $display("FAIL deb_edge3_latched: got %b exp 000000", o_alarm_latched); end
        tick();
        checks++; if (o_alarm_latched !== 6'b000100) begin errors++; $display("FAIL deb_latched: got %b exp 000100", o_alarm_latched); end
        checks++; if (o_not_alarm !== 1'b0) begin errors++; $display("FAIL deb_not_alarm: got %b exp 0", o_not_alarm); end
        checks++; if (o_first_fault !== (FF_EN ? 3'd2 : 3'd0)) begin errors++; $display("FAIL deb_first_fault: got %0d exp %0d", o_first_fault, FF_EN ? 2 : 0); end
        checks++; if (o_first_valid !== FF_EN) begin errors++; $display("FAIL deb_first_valid: got %b exp %b", o_first_valid, FF_EN); end
        i_control = 6'b0;
        pulse_ack();
        checks++; if (o_alarm_latched !== 6'b0) begin errors++; $display("FAIL deb_ack_latched: got %b exp 000000", o_alarm_latched); end
        checks++; if (o_not_alarm !== 1'b1) begin errors++; $display("FAIL deb_ack_not_alarm: got %b exp 1", o_not_alarm); end
    endtask

    task automatic test_simultaneous();
        i_control = 6'b100010;
        tick(4);
        checks++; if (o_alarm_latched !== 6'b100010) begin errors++; $display("FAIL sim_latched: got %b exp 100010", o_alarm_latched); end
        checks++; if (o_first_fault !== (FF_EN ? 3'd1 : 3'd0)) begin errors++; $display("FAIL sim_first_fault: got %0d exp %0d", o_first_fault, FF_EN ? 1 : 0); end
        i_control = 6'b100011;
        tick(4);
        checks++; if (o_alarm_latched !== 6'b100011) begin errors++; $display("FAIL sim_later_latched: got %b exp 100011", o_alarm_latched); end
        checks++; if (o_first_fault !== (FF_EN ? 3'd1 : 3'd0)) begin errors++; $display("FAIL sim_later_first_fault: got %0d exp %0d", o_first_fault, FF_EN ? 1 : 0); end
        i_control = 6'b0;
        pulse_ack();
        checks++; if (o_not_alarm !== 1'b1) begin errors++; $display("FAIL sim_clear_not_alarm: got %b exp 1", o_not_alarm); end
        checks++; if (o_first_valid !== 1'b0) begin errors++; $display("FAIL sim_clear_first_valid: got %b exp 0", o_first_valid); end
    endtask

    task automatic test_ack_active();
        i_control = 6'b001000;
        tick(4);
        pulse_ack();
        checks++; if (o_alarm_latched !== 6'b001000) begin errors++; $display("FAIL ackact_latched: got %b exp 001000", o_alarm_latched); end
        checks++; if (o_not_alarm !== 1'b0) begin errors++; $display("FAIL ackact_not_alarm: got %b exp 0", o_not_alarm); end
        i_control = 6'b0;
        tick();
        checks++; if (o_alarm_latched !== 6'b001000) begin errors++; $display("FAIL ackact_hold: got %b exp 001000", o_alarm_latched); end
        pulse_ack();
        checks++; if (o_alarm_latched !== 6'b0) begin errors++; $display("FAIL ackact_clear_latched: got %b exp 000000", o_alarm_latched); end
        checks++; if (o_not_alarm !== 1'b1) begin errors++; $display("FAIL ackact_clear_not_alarm: got %b exp 1", o_not_alarm); end
        checks++; if (o_first_valid !== 1'b0) begin errors++; $display("FAIL ackact_first_valid: got %b exp 0", o_first_valid); end
    endtask

    task automatic test_emergency();
        i_control = 6'b000010;
        tick(4);
        checks++; if (o_not_alarm !== 1'b0) begin errors++; $display("FAIL em_alarm: got %b exp 0", o_not_alarm); end
        i_external = 1'b1;
        tick();
        checks++; if (o_emergency !== 1'b1) begin errors++; $display("FAIL em_enter: got %b exp 1", o_emergency); end
        checks++; if (o_not_alarm !== 1'b0) begin errors++; $display("FAIL em_not_alarm: got %b exp 0", o_not_alarm); end
        pulse_ack();
        checks++; if (o_emergency !== 1'b1) begin errors++; $display("FAIL em_ack_while_ext: got %b exp 1", o_emergency); end
        checks++; if (o_alarm_latched !== 6'b000010) begin errors++; $display("FAIL em_ack_latched: got %b exp 000010", o_alarm_latched); end
        i_external = 1'b0;
        tick();
        checks++; if (o_emergency !== 1'b1) begin errors++; $display("FAIL em_release_hold: got %b exp 1", o_emergency); end
        pulse_ack();
        checks++; if (o_emergency !== 1'b0) begin errors++; $display("FAIL em_exit_emergency: got %b exp 0", o_emergency); end
        checks++; if (o_not_alarm !== 1'b0) begin errors++; $display("FAIL em_exit_to_alarm: got %b exp 0", o_not_alarm); end
        checks++; if (o_alarm_latched !== 6'b000010) begin errors++; $display("FAIL em_exit_latched: got %b exp 000010", o_alarm_latched); end
        i_control = 6'b0;
        tick();
        pulse_ack();
        checks++; if (o_not_alarm !== 1'b1) begin errors++; $display("FAIL em_cleanup: got %b exp 1", o_not_alarm); end
        // Emergency entered from RUN on a single-cycle pulse, then acked back to RUN.
        i_external = 1'b1;
        tick();
        i_external = 1'b0;
        checks++; if (o_emergency !== 1'b1) begin errors++; $display("FAIL em_run_pulse: got %b exp 1", o_emergency); end
        pulse_ack();
        checks++; if (o_not_alarm !== 1'b1) begin errors++; $display("FAIL em_run_exit: got %b exp 1", o_not_alarm); end
        checks++; if (o_emergency !== 1'b0) begin errors++; $display("FAIL em_run_exit_em: got %b exp 0", o_emergency); end
    endtask

    task automatic test_tune();
        i_i_an_5a = 1'b1;
        i_i_an_6a = 1'b0;
        i_not_tune_ok = 1'b1;
        tick(2);
        i_not_tune_ok = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++; if (o_i_an_high !== 1'b0) begin errors++; $display("FAIL tune_untuned_edge%0d: got %b exp 0", e, o_i_an_high); end
        end
        tick();
        checks++; if (o_i_an_high !== 1'b1) begin errors++; $display("FAIL tune_edge9: got %b exp 1", o_i_an_high); end
        tick(3);
        checks++; if (o_i_an_high !== 1'b1) begin errors++; $display("FAIL tune_hold: got %b exp 1", o_i_an_high); end
        i_not_tune_ok = 1'b1;
        tick();
        checks++; if (o_i_an_high !== 1'b0) begin errors++; $display("FAIL tune_drop: got %b exp 0", o_i_an_high); end
        i_i_an_5a = 1'b0;
        i_i_an_6a = 1'b1;
        tick();
        checks++; if (o_i_an_high !== 1'b1) begin errors++; $display("FAIL tune_6a_untuned: got %b exp 1", o_i_an_high); end
        i_i_an_6a = 1'b0;
    endtask

    task automatic test_reset_in_emerg();
        i_control = 6'b010000;
        i_i_an_5a = 1'b1;
        i_not_tune_ok = 1'b1;
        tick(4);
        i_external = 1'b1;
        tick();
        checks++; if (o_emergency !== 1'b1) begin errors++; $display("FAIL rst_em_setup: got %b exp 1", o_emergency); end
        checks++; if (o_i_an_high !== 1'b0) begin errors++; $display("FAIL rst_em_an_setup: got %b exp 0", o_i_an_high); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_external = 1'b0;
        i_control = 6'b0;
        i_i_an_5a = 1'b0;
        checks++; if (o_emergency !== 1'b0) begin errors++; $display("FAIL rst_em_emergency: got %b exp 0", o_emergency); end
        checks++; if (o_not_alarm !== 1'b1) begin errors++; $display("FAIL rst_em_not_alarm: got %b exp 1", o_not_alarm); end
        checks++; if (o_alarm_latched !== 6'b0) begin errors++; $display("FAIL rst_em_latched: got %b exp 000000", o_alarm_latched); end
        checks++; if (o_i_an_high !== 1'b1) begin errors++; $display("FAIL rst_em_an_high: got %b exp 1", o_i_an_high); end
        checks++; if (o_first_fault !== 3'd0) begin errors++; $display("FAIL rst_em_first_fault: got %0d exp 0", o_first_fault); end
        checks++; if (o_first_valid !== 1'b0) begin errors++; $display("FAIL rst_em_first_valid: got %b exp 0", o_first_valid); end
        tick();
        checks++; if (o_not_alarm !== 1'b1) begin errors++; $display("FAIL rst_em_after: got %b exp 1", o_not_alarm); end
    endtask

    initial begin
        reset = 1'b1;
        i_control = '0;
        i_external = 1'b0;
        i_not_tune_ok = 1'b1;
        i_i_an_5a = 1'b0;
        i_i_an_6a = 1'b0;
        i_ack = 1'b0;
        test_reset();
        test_debounce();
        test_simultaneous();
        test_ack_active();
        test_emergency();
        test_tune();
        test_reset_in_emerg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
